// File: rtl/dmem_pkg.sv
// Shared types and constants for the byte-serial data-memory controller.
package dmem_pkg;

   typedef enum logic [1:0] {IDLE, WAIT, XFER, RESP} state_t;

   localparam int BYTES_PER_WORD = 4;

   // Big-endian: byte 0 of a transfer is the word's top lane, so lane k sits 8k bits below it.
   localparam int MSB_LANE_LSB = 8 * (BYTES_PER_WORD - 1);

   function automatic logic [7:0] word_lane(input logic [31:0] word, input logic [1:0] k);
      return word[MSB_LANE_LSB - 8 * int'(k) +: 8];
   endfunction

endpackage

// File: rtl/dmem_byte_array.sv
// Byte-wide storage: one synchronous write port, one combinational read port
// and one combinational debug peek port. Contents are not cleared by reset.
module dmem_byte_array #(
   parameter int DEPTH  = 32,
   parameter int ADDR_W = 5
) (
   input  logic              clk,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [7:0]        wdata,
   input  logic [ADDR_W-1:0] raddr,
   output logic [7:0]        rdata,
   input  logic [ADDR_W-1:0] dbg_addr,
   output logic [7:0]        dbg_byte
);

   logic [7:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   assign rdata    = mem[raddr];
   assign dbg_byte = mem[dbg_addr];

endmodule

// File: rtl/dmem_ctrl.sv
// Handshaked data-memory controller: accepts one word request at a time and
// moves it byte-serially (big-endian) through the byte array.
module dmem_ctrl
   import dmem_pkg::*;
#(
   parameter int DEPTH       = 32,
   parameter int ADDR_W      = 5,
   parameter int WAIT_CYCLES = 0
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [31:0]       req_wdata,
   output logic              rsp_valid,
   output logic [31:0]       rsp_rdata,
   output logic              busy,
   input  logic [ADDR_W-1:0] dbg_addr,
   output logic [7:0]        dbg_byte
);

   localparam logic [3:0] WAIT_LAST = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;
   localparam logic [1:0] LAST_BYTE = 2'(BYTES_PER_WORD - 1);

   state_t            state_q;
   state_t            state_d;
   logic [ADDR_W-1:0] addr_q;
   logic              we_q;
   logic [31:0]       wdata_q;
   logic [1:0]        byte_cnt;
   logic [3:0]        wait_cnt;
   logic [23:0]       rd_shift;
   logic [ADDR_W-1:0] xfer_addr;
   logic [7:0]        wr_byte;
   logic [7:0]        rd_byte;
   logic              mem_we;
   logic              accept;

   assign accept    = req_valid && req_ready;
   assign req_ready = (state_q == IDLE);
   assign busy      = (state_q != IDLE);
   assign rsp_valid = (state_q == RESP);

   // Power-of-two depth makes the address sum wrap silently at the array end.
   assign xfer_addr = addr_q + ADDR_W'(byte_cnt);
   assign wr_byte   = word_lane(wdata_q, byte_cnt);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      mem_we  = 1'b0;
      case (state_q)
         IDLE: begin
            if (accept) begin
               state_d = (WAIT_CYCLES > 0) ? WAIT : XFER;
            end
         end
         WAIT: begin
            if (wait_cnt == WAIT_LAST) begin
               state_d = XFER;
            end
         end
         XFER: begin
            mem_we = we_q;
            if (byte_cnt == LAST_BYTE) begin
               state_d = RESP;
            end
         end
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Operands are captured once at accept so the core may move on immediately;
   // load bytes shift in MSB-first and the result lands as RESP is entered.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         addr_q    <= '0;
         we_q      <= 1'b0;
         wdata_q   <= '0;
         byte_cnt  <= '0;
         wait_cnt  <= '0;
         rd_shift  <= '0;
         rsp_rdata <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (accept) begin
                  addr_q   <= req_addr;
                  we_q     <= req_we;
                  wdata_q  <= req_wdata;
                  byte_cnt <= '0;
                  wait_cnt <= '0;
               end
            end
            WAIT: wait_cnt <= wait_cnt + 4'd1;
            XFER: begin
               byte_cnt <= byte_cnt + 2'd1;
               rd_shift <= {rd_shift[15:0], rd_byte};
               if (byte_cnt == LAST_BYTE) begin
                  rsp_rdata <= we_q ? 32'd0 : {rd_shift, rd_byte};
               end
            end
            default: ;
         endcase
      end
   end

   dmem_byte_array #(
      .DEPTH  (DEPTH),
      .ADDR_W (ADDR_W)
   ) u_array (
      .clk      (clk),
      .we       (mem_we),
      .waddr    (xfer_addr),
      .wdata    (wr_byte),
      .raddr    (xfer_addr),
      .rdata    (rd_byte),
      .dbg_addr (dbg_addr),
      .dbg_byte (dbg_byte)
   );

endmodule

// File: tb/tb_dmem_ctrl.sv
// Bench for dmem_ctrl: two instances (no wait states and three wait states)
// checked every cycle against a transaction-level model plus literal checks.
module tb_dmem_ctrl;

   localparam int W0 = 0;
   localparam int W1 = 3;

   logic            clk = 1'b0;
   logic            rst_n;
   logic [1:0]      req_valid, req_ready, req_we, rsp_valid, busy;
   logic [1:0][4:0] req_addr, dbg_addr;
   logic [1:0][31:0] req_wdata, rsp_rdata;
   logic [1:0][7:0] dbg_byte;

   always #5 clk = ~clk;

   dmem_ctrl #(.DEPTH(32), .ADDR_W(5), .WAIT_CYCLES(W0)) dut0 (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_we(req_we[0]),
      .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
      .rsp_valid(rsp_valid[0]), .rsp_rdata(rsp_rdata[0]), .busy(busy[0]),
      .dbg_addr(dbg_addr[0]), .dbg_byte(dbg_byte[0])
   );

   dmem_ctrl #(.DEPTH(32), .ADDR_W(5), .WAIT_CYCLES(W1)) dut3 (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_we(req_we[1]),
      .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
      .rsp_valid(rsp_valid[1]), .rsp_rdata(rsp_rdata[1]), .busy(busy[1]),
      .dbg_addr(dbg_addr[1]), .dbg_byte(dbg_byte[1])
   );

   int          cyc = 0;
   int          n_checks = 0;
   int          n_fail = 0;
   bit          checking = 1'b0;
   int          wait_of [2] = '{W0, W1};
   bit          act [2];
   int          acc_e [2];
   logic        m_we [2];
   int          m_addr [2];
   logic [31:0] m_wdata [2];
   logic [31:0] m_rdata [2];
   logic [7:0]  m_mem [2][32];
   bit          m_known [2][32];

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      n_checks++;
      if (actual !== expected) begin
         n_fail++;
         $display("[TB] FAIL %s: got 0x%08h, required 0x%08h", name, actual, expected);
      end
   endtask

   // Transaction model: a request occupies the instance for WAIT+5 cycles,
   // byte k moves on edge accept+WAIT+1+k, the response shows in cycle WAIT+5.
   initial begin
      for (int i = 0; i < 2; i++) begin
         act[i] = 1'b0;
         m_rdata[i] = 32'd0;
         for (int j = 0; j < 32; j++) m_known[i][j] = 1'b0;
      end
      forever begin
         @(posedge clk or negedge rst_n);
         if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
               act[i] = 1'b0;
               m_rdata[i] = 32'd0;
            end
         end else begin
            cyc++;
            for (int i = 0; i < 2; i++) begin
               if (act[i]) begin
                  int k;
                  k = cyc - acc_e[i] - wait_of[i] - 1;
                  if (m_we[i] && k >= 0 && k < 4) begin
                     m_mem[i][(m_addr[i] + k) % 32]   = 8'((m_wdata[i] >> (24 - 8 * k)) & 32'hFF);
                     m_known[i][(m_addr[i] + k) % 32] = 1'b1;
                  end
                  if (k == 3) begin
                     m_rdata[i] = m_we[i] ? 32'd0 :
                        {m_mem[i][m_addr[i]], m_mem[i][(m_addr[i] + 1) % 32],
                         m_mem[i][(m_addr[i] + 2) % 32], m_mem[i][(m_addr[i] + 3) % 32]};
                  end
                  if (k == 4) act[i] = 1'b0;
               end else if (req_valid[i]) begin
                  act[i]     = 1'b1;
                  acc_e[i]   = cyc;
                  m_we[i]    = req_we[i];
                  m_addr[i]  = int'(req_addr[i]);
                  m_wdata[i] = req_wdata[i];
               end
            end
         end
      end
   end

   initial begin
      wait (checking);
      forever begin
         @(negedge clk);
         for (int i = 0; i < 2; i++) begin
            checkOutput($sformatf("inst%0d req_ready", i), 32'(req_ready[i]), 32'(!act[i]));
            checkOutput($sformatf("inst%0d busy", i), 32'(busy[i]), 32'(act[i]));
            checkOutput($sformatf("inst%0d rsp_valid", i), 32'(rsp_valid[i]),
                        32'(act[i] && (cyc - acc_e[i] - wait_of[i] - 1 == 3)));
            checkOutput($sformatf("inst%0d rsp_rdata", i), rsp_rdata[i], m_rdata[i]);
            if (m_known[i][dbg_addr[i]]) begin
               checkOutput($sformatf("inst%0d dbg_byte[%0d]", i, dbg_addr[i]),
                           32'(dbg_byte[i]), 32'(m_mem[i][dbg_addr[i]]));
            end
         end
      end
   end

   // Returns at the falling edge right after the accept edge.
   task automatic applyStimulus(input int i, input logic we, input logic [4:0] addr,
                                input logic [31:0] wdata, input bit hold, output int acc);
      acc = -1;
      @(negedge clk);
      req_we[i]    = we;
      req_addr[i]  = addr;
      req_wdata[i] = wdata;
      req_valid[i] = 1'b1;
      for (int n = 0; n < 40 && acc < 0; n++) begin
         if (req_ready[i]) acc = cyc + 1;
         @(negedge clk);
      end
      if (!hold) req_valid[i] = 1'b0;
      if (acc < 0) checkOutput($sformatf("inst%0d accept timeout", i), 32'd0, 32'd1);
   endtask

   task automatic waitResponse(input int i, input int acc, input int exp_lat,
                               input logic [31:0] exp_data, input string name);
      int lat = -1;
      int busy_n = 0;
      int nready_n = 0;
      logic [31:0] data = 'x;
      for (int n = 0; n < 40 && lat < 0; n++) begin
         if (busy[i]) busy_n++;
         if (!req_ready[i]) nready_n++;
         if (rsp_valid[i]) begin
            lat  = cyc - acc + 1;
            data = rsp_rdata[i];
         end else begin
            @(negedge clk);
         end
      end
      checkOutput({name, " latency"}, 32'(lat), 32'(exp_lat));
      checkOutput({name, " busy cycles"}, 32'(busy_n), 32'(exp_lat));
      checkOutput({name, " ready-low cycles"}, 32'(nready_n), 32'(exp_lat));
      checkOutput({name, " rsp_rdata"}, data, exp_data);
   endtask

   task automatic peekByte(input int i, input logic [4:0] a, input logic [7:0] expected, input string name);
      @(posedge clk);
      #2;
      dbg_addr[i] = a;
      #1;
      checkOutput(name, 32'(dbg_byte[i]), 32'(expected));
   endtask

   initial begin
      int a;
      int a2;
      int pulses;
      rst_n     = 1'b1;
      req_valid = '0;
      req_we    = '0;
      req_addr  = '0;
      req_wdata = '0;
      dbg_addr  = '0;
      #1 rst_n = 1'b0;
      repeat (3) @(negedge clk);
      checking = 1'b1;
      for (int i = 0; i < 2; i++) begin
         checkOutput($sformatf("inst%0d reset req_ready", i), 32'(req_ready[i]), 32'd1);
         checkOutput($sformatf("inst%0d reset busy", i), 32'(busy[i]), 32'd0);
         checkOutput($sformatf("inst%0d reset rsp_valid", i), 32'(rsp_valid[i]), 32'd0);
         checkOutput($sformatf("inst%0d reset rsp_rdata", i), rsp_rdata[i], 32'd0);
      end
      #2 rst_n = 1'b1;

      applyStimulus(0, 1'b1, 5'd4, 32'hDEADBEEF, 1'b0, a);
      waitResponse(0, a, 5, 32'd0, "store 4");
      peekByte(0, 5'd4, 8'hDE, "mem[4]");
      peekByte(0, 5'd5, 8'hAD, "mem[5]");
      peekByte(0, 5'd6, 8'hBE, "mem[6]");
      peekByte(0, 5'd7, 8'hEF, "mem[7]");
      applyStimulus(0, 1'b0, 5'd4, 32'h0, 1'b0, a);
      waitResponse(0, a, 5, 32'hDEADBEEF, "load 4");

      applyStimulus(0, 1'b1, 5'd30, 32'h11223344, 1'b0, a);
      waitResponse(0, a, 5, 32'd0, "store 30");
      peekByte(0, 5'd30, 8'h11, "mem[30]");
      peekByte(0, 5'd31, 8'h22, "mem[31]");
      peekByte(0, 5'd0, 8'h33, "mem[0]");
      peekByte(0, 5'd1, 8'h44, "mem[1]");
      applyStimulus(0, 1'b0, 5'd30, 32'h0, 1'b0, a);
      waitResponse(0, a, 5, 32'h11223344, "load 30");

      // Request stays asserted with different operands while the store runs.
      applyStimulus(0, 1'b1, 5'd12, 32'hCAFEF00D, 1'b1, a);
      req_we[0]    = 1'b0;
      req_addr[0]  = 5'd20;
      req_wdata[0] = 32'hFFFFFFFF;
      waitResponse(0, a, 5, 32'd0, "held store");
      applyStimulus(0, 1'b0, 5'd12, 32'h0, 1'b0, a2);
      waitResponse(0, a2, 5, 32'hCAFEF00D, "held load");
      checkOutput("second rsp offset", 32'(a2 - a + 5), 32'd11);
      peekByte(0, 5'd12, 8'hCA, "mem[12]");

      applyStimulus(0, 1'b1, 5'd8, 32'h5A5A5A5A, 1'b0, a);
      waitResponse(0, a, 5, 32'd0, "prefill 8");
      applyStimulus(0, 1'b1, 5'd8, 32'hAABBCCDD, 1'b0, a);
      @(negedge clk);
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      checkOutput("abort req_ready", 32'(req_ready[0]), 32'd1);
      checkOutput("abort busy", 32'(busy[0]), 32'd0);
      checkOutput("abort rsp_valid", 32'(rsp_valid[0]), 32'd0);
      checkOutput("abort rsp_rdata", rsp_rdata[0], 32'd0);
      peekByte(0, 5'd8, 8'hAA, "abort mem[8]");
      peekByte(0, 5'd9, 8'hBB, "abort mem[9]");
      peekByte(0, 5'd10, 8'h5A, "abort mem[10]");
      peekByte(0, 5'd11, 8'h5A, "abort mem[11]");
      @(negedge clk);
      #2 rst_n = 1'b1;
      pulses = 0;
      repeat (10) begin
         @(negedge clk);
         if (rsp_valid[0]) pulses++;
      end
      checkOutput("abort rsp pulses", 32'(pulses), 32'd0);

      applyStimulus(1, 1'b1, 5'd0, 32'h13579BDF, 1'b0, a);
      waitResponse(1, a, 8, 32'd0, "wait3 store 0");
      peekByte(1, 5'd0, 8'h13, "wait3 mem[0]");
      applyStimulus(1, 1'b0, 5'd0, 32'h0, 1'b0, a);
      waitResponse(1, a, 8, 32'h13579BDF, "wait3 load 0");

      repeat (2) @(negedge clk);
      $display("[TB] End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: got no end of test, required finish within 100000 time units");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
